// File: rtl/dp_pkg.sv
// Shared encodings for the caminho_dados_param datapath: bus selects,
// address source and the Bus1 select width helper.
package dp_pkg;

  localparam logic [1:0] BUS2_BUS1 = 2'd0;
  localparam logic [1:0] BUS2_ONE  = 2'd1;
  localparam logic [1:0] BUS2_MEM  = 2'd2;
  localparam logic [1:0] BUS2_ALU  = 2'd3;

  localparam int SEL_PC = 0;
  localparam int SEL_SP = 1;
  localparam int SEL_R0 = 2;

  localparam logic ADDR_MAR = 1'b0;
  localparam logic ADDR_SP  = 1'b1;

  // PC and SP occupy the two lowest Bus1 codes ahead of the register file
  function automatic int sel_width(input int nregs);
    return $clog2(nregs + 2);
  endfunction

endpackage

// File: rtl/caminho_dados_param_if.sv
// Control/data bundle between the control unit (master) and the datapath (slave).
interface caminho_dados_param_if
  import dp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int SELW = sel_width(NREGS);

  logic [SELW-1:0]        Bus1_Sel;
  logic [1:0]             Bus2_Sel;
  logic [NREGS-1:0]       Reg_Load;
  logic                   PC_Load;
  logic                   PC_Inc;
  logic                   IR_Load;
  logic                   MAR_Load;
  logic                   CCR_Load;
  logic                   SP_Load;
  logic                   SP_Inc;
  logic                   SP_Dec;
  logic                   Addr_Sel;
  logic [WIDTH-1:0]       ALU_Result;
  logic [WIDTH-1:0]       from_memory;
  logic [3:0]             NZVC;
  logic [WIDTH-1:0]       to_memory;
  logic [WIDTH-1:0]       address;
  logic [WIDTH-1:0]       IR;
  logic [WIDTH-1:0]       PC;
  logic [WIDTH-1:0]       MAR;
  logic [WIDTH-1:0]       SP;
  logic [3:0]             CCR;
  logic [NREGS*WIDTH-1:0] Regs;
  logic                   Stack_Err;

  modport master (
    output Bus1_Sel, Bus2_Sel, Reg_Load, PC_Load, PC_Inc, IR_Load, MAR_Load,
           CCR_Load, SP_Load, SP_Inc, SP_Dec, Addr_Sel, ALU_Result,
           from_memory, NZVC,
    input  to_memory, address, IR, PC, MAR, SP, CCR, Regs, Stack_Err
  );

  modport slave (
    input  Bus1_Sel, Bus2_Sel, Reg_Load, PC_Load, PC_Inc, IR_Load, MAR_Load,
           CCR_Load, SP_Load, SP_Inc, SP_Dec, Addr_Sel, ALU_Result,
           from_memory, NZVC,
    output to_memory, address, IR, PC, MAR, SP, CCR, Regs, Stack_Err
  );

endinterface

// File: rtl/caminho_dados_param_reg.sv
// Generic load-enabled register with asynchronous active-high reset to RST_VAL.
module dp_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_q <= RST_VAL;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/caminho_dados_param.sv
// Two-bus processor datapath: register file, PC, IR, MAR, CCR and a hardware
// stack pointer with a sticky overflow/underflow flag. No decode logic lives here.
module caminho_dados_param
  import dp_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               NREGS   = 4,
  parameter logic [WIDTH-1:0] SP_INIT = '1
) (
  input  logic                 clock,
  input  logic                 reset,
  caminho_dados_param_if.slave bus
);

  localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_bus1;
  logic [WIDTH-1:0] w_bus2;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_sp;
  logic [WIDTH-1:0] w_ir;
  logic [WIDTH-1:0] w_mar;
  logic [3:0]       w_ccr;
  logic             r_stack_err;
  logic             w_sp_up;
  logic             w_sp_down;
  logic             w_sp_wrap;
  logic [WIDTH-1:0] w_regs [NREGS];

  // Unmatched select codes fall through to the zero default
  always_comb begin
    w_bus1 = '0;
    if (int'(bus.Bus1_Sel) == SEL_PC) begin
      w_bus1 = r_pc;
    end else if (int'(bus.Bus1_Sel) == SEL_SP) begin
      w_bus1 = r_sp;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        if (int'(bus.Bus1_Sel) == SEL_R0 + n) w_bus1 = w_regs[n];
      end
    end
  end

  always_comb begin
    w_bus2 = w_bus1;
    case (bus.Bus2_Sel)
      BUS2_BUS1: w_bus2 = w_bus1;
      BUS2_ONE:  w_bus2 = W_ONE;
      BUS2_MEM:  w_bus2 = bus.from_memory;
      BUS2_ALU:  w_bus2 = bus.ALU_Result;
      default:   w_bus2 = w_bus1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            r_pc <= '0;
    else if (bus.PC_Load) r_pc <= w_bus2;
    else if (bus.PC_Inc)  r_pc <= r_pc + W_ONE;
  end

  assign w_sp_up   = bus.SP_Inc & ~bus.SP_Dec;
  assign w_sp_down = bus.SP_Dec & ~bus.SP_Inc;
  assign w_sp_wrap = (w_sp_up & (r_sp == '1)) | (w_sp_down & (r_sp == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            r_sp <= SP_INIT;
    else if (bus.SP_Load) r_sp <= w_bus2;
    else if (w_sp_up)     r_sp <= r_sp + W_ONE;
    else if (w_sp_down)   r_sp <= r_sp - W_ONE;
  end

  // A load both resets the flag and masks any wrap in the same cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            r_stack_err <= 1'b0;
    else if (bus.SP_Load) r_stack_err <= 1'b0;
    else if (w_sp_wrap)   r_stack_err <= 1'b1;
  end

  dp_reg #(.W(WIDTH)) u_ir (
    .clock (clock), .reset (reset), .i_load (bus.IR_Load),
    .i_d   (w_bus2), .o_q (w_ir)
  );

  dp_reg #(.W(WIDTH)) u_mar (
    .clock (clock), .reset (reset), .i_load (bus.MAR_Load),
    .i_d   (w_bus2), .o_q (w_mar)
  );

  dp_reg #(.W(4)) u_ccr (
    .clock (clock), .reset (reset), .i_load (bus.CCR_Load),
    .i_d   (bus.NZVC), .o_q (w_ccr)
  );

  for (genvar n = 0; n < NREGS; n++) begin : g_regs
    dp_reg #(.W(WIDTH)) u_r (
      .clock (clock), .reset (reset), .i_load (bus.Reg_Load[n]),
      .i_d   (w_bus2), .o_q (w_regs[n])
    );
    assign bus.Regs[n*WIDTH +: WIDTH] = w_regs[n];
  end

  assign bus.to_memory = w_bus1;
  assign bus.address   = (bus.Addr_Sel == ADDR_SP) ? r_sp : w_mar;
  assign bus.IR        = w_ir;
  assign bus.PC        = r_pc;
  assign bus.MAR       = w_mar;
  assign bus.SP        = r_sp;
  assign bus.CCR       = w_ccr;
  assign bus.Stack_Err = r_stack_err;

endmodule

// File: tb/tb_caminho_dados_param.sv
// Bench for caminho_dados_param: vector table with a scoreboard queue on an
// 8-bit/4-register build, plus reset and wide-build (16-bit/8-register) sequences.
module tb_caminho_dados_param;
  import dp_pkg::*;

  localparam logic [8:0] PCL  = 9'h100;
  localparam logic [8:0] PCI  = 9'h080;
  localparam logic [8:0] IRL  = 9'h040;
  localparam logic [8:0] MARL = 9'h020;
  localparam logic [8:0] CCRL = 9'h010;
  localparam logic [8:0] SPL  = 9'h008;
  localparam logic [8:0] SPI  = 9'h004;
  localparam logic [8:0] SPD  = 9'h002;
  localparam logic [8:0] AS   = 9'h001;
  localparam int NV = 26;

  typedef struct {
    logic [2:0]  b1;
    logic [1:0]  b2;
    logic [3:0]  rl;
    logic [8:0]  ctl;
    logic [7:0]  alu;
    logic [7:0]  mem;
    logic [3:0]  nzvc;
    logic [7:0]  e_tomem;
    logic [7:0]  e_addr;
    logic [7:0]  e_pc;
    logic [7:0]  e_sp;
    logic        e_err;
    logic [31:0] e_regs;
    logic [7:0]  e_ir;
    logic [7:0]  e_mar;
    logic [3:0]  e_ccr;
  } vec_t;

  typedef struct {
    int          idx;
    logic [7:0]  pc;
    logic [7:0]  sp;
    logic        err;
    logic [31:0] regs;
    logic [7:0]  ir;
    logic [7:0]  mar;
    logic [3:0]  ccr;
  } exp_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vt [NV];
  exp_t sb [$];

  caminho_dados_param_if #(.WIDTH(8),  .NREGS(4)) bus8  ();
  caminho_dados_param_if #(.WIDTH(16), .NREGS(8)) bus16 ();

  caminho_dados_param #(.WIDTH(8), .NREGS(4)) dut8 (
    .clock (clock), .reset (reset), .bus (bus8)
  );

  caminho_dados_param #(.WIDTH(16), .NREGS(8)) dut16 (
    .clock (clock), .reset (reset), .bus (bus16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(
    input logic [2:0] b1, input logic [1:0] b2, input logic [3:0] rl,
    input logic [8:0] ctl, input logic [7:0] alu, input logic [7:0] mem,
    input logic [3:0] nz, input logic [7:0] etm, input logic [7:0] ead,
    input logic [7:0] epc, input logic [7:0] esp, input logic eerr,
    input logic [31:0] ereg, input logic [7:0] eir, input logic [7:0] emar,
    input logic [3:0] eccr);
    vec_t r;
    r.b1 = b1; r.b2 = b2; r.rl = rl; r.ctl = ctl; r.alu = alu; r.mem = mem;
    r.nzvc = nz; r.e_tomem = etm; r.e_addr = ead; r.e_pc = epc; r.e_sp = esp;
    r.e_err = eerr; r.e_regs = ereg; r.e_ir = eir; r.e_mar = emar; r.e_ccr = eccr;
    return r;
  endfunction

  task automatic drive8(input vec_t x);
    bus8.Bus1_Sel    = x.b1;
    bus8.Bus2_Sel    = x.b2;
    bus8.Reg_Load    = x.rl;
    bus8.PC_Load     = x.ctl[8];
    bus8.PC_Inc      = x.ctl[7];
    bus8.IR_Load     = x.ctl[6];
    bus8.MAR_Load    = x.ctl[5];
    bus8.CCR_Load    = x.ctl[4];
    bus8.SP_Load     = x.ctl[3];
    bus8.SP_Inc      = x.ctl[2];
    bus8.SP_Dec      = x.ctl[1];
    bus8.Addr_Sel    = x.ctl[0];
    bus8.ALU_Result  = x.alu;
    bus8.from_memory = x.mem;
    bus8.NZVC        = x.nzvc;
  endtask

  task automatic idle16();
    bus16.Bus1_Sel = '0; bus16.Bus2_Sel = '0; bus16.Reg_Load = '0;
    bus16.PC_Load = 1'b0; bus16.PC_Inc = 1'b0; bus16.IR_Load = 1'b0;
    bus16.MAR_Load = 1'b0; bus16.CCR_Load = 1'b0; bus16.SP_Load = 1'b0;
    bus16.SP_Inc = 1'b0; bus16.SP_Dec = 1'b0; bus16.Addr_Sel = 1'b0;
    bus16.ALU_Result = '0; bus16.from_memory = '0; bus16.NZVC = '0;
  endtask

  task automatic step8(input int i);
    exp_t e;
    drive8(vt[i]);
    #1;
    chk($sformatf("v%0d to_memory", i), 64'(bus8.to_memory), 64'(vt[i].e_tomem));
    chk($sformatf("v%0d address", i),   64'(bus8.address),   64'(vt[i].e_addr));
    e.idx = i; e.pc = vt[i].e_pc; e.sp = vt[i].e_sp; e.err = vt[i].e_err;
    e.regs = vt[i].e_regs; e.ir = vt[i].e_ir; e.mar = vt[i].e_mar; e.ccr = vt[i].e_ccr;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d PC", e.idx),        64'(bus8.PC),        64'(e.pc));
    chk($sformatf("v%0d SP", e.idx),        64'(bus8.SP),        64'(e.sp));
    chk($sformatf("v%0d Stack_Err", e.idx), 64'(bus8.Stack_Err), 64'(e.err));
    chk($sformatf("v%0d Regs", e.idx),      64'(bus8.Regs),      64'(e.regs));
    chk($sformatf("v%0d IR", e.idx),        64'(bus8.IR),        64'(e.ir));
    chk($sformatf("v%0d MAR", e.idx),       64'(bus8.MAR),       64'(e.mar));
    chk($sformatf("v%0d CCR", e.idx),       64'(bus8.CCR),       64'(e.ccr));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //         b1 b2         rl    ctl        alu    mem    nz    tomem  addr   pc     sp     err   regs          ir     mar    ccr
    vt[0]  = v(0, BUS2_MEM,  4'h8, 9'h0,      8'h00, 8'h5A, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 32'h5A000000, 8'h00, 8'h00, 4'h0);
    vt[1]  = v(5, BUS2_BUS1, 4'h1, 9'h0,      8'h00, 8'h00, 4'h0, 8'h5A, 8'h00, 8'h00, 8'hFF, 1'b0, 32'h5A00005A, 8'h00, 8'h00, 4'h0);
    vt[2]  = v(0, BUS2_ALU,  4'h6, 9'h0,      8'h33, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 32'h5A33335A, 8'h00, 8'h00, 4'h0);
    vt[3]  = v(7, BUS2_BUS1, 4'h2, 9'h0,      8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0, 32'h5A33005A, 8'h00, 8'h00, 4'h0);
    vt[4]  = v(0, BUS2_ONE,  4'h0, PCL|MARL,  8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h01, 8'hFF, 1'b0, 32'h5A33005A, 8'h00, 8'h01, 4'h0);
    vt[5]  = v(0, BUS2_ALU,  4'h0, PCL|IRL,   8'hFF, 8'h00, 4'h0, 8'h01, 8'h01, 8'hFF, 8'hFF, 1'b0, 32'h5A33005A, 8'hFF, 8'h01, 4'h0);
    vt[6]  = v(0, BUS2_BUS1, 4'h0, PCI,       8'h00, 8'h00, 4'h0, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0, 32'h5A33005A, 8'hFF, 8'h01, 4'h0);
    vt[7]  = v(0, BUS2_ALU,  4'h0, PCL|PCI,   8'h40, 8'h00, 4'h0, 8'h00, 8'h01, 8'h40, 8'hFF, 1'b0, 32'h5A33005A, 8'hFF, 8'h01, 4'h0);
    vt[8]  = v(2, BUS2_ALU,  4'h1, 9'h0,      8'hA5, 8'h00, 4'h0, 8'h5A, 8'h01, 8'h40, 8'hFF, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[9]  = v(1, BUS2_ALU,  4'h0, SPL,       8'h00, 8'h00, 4'h0, 8'hFF, 8'h01, 8'h40, 8'h00, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[10] = v(1, BUS2_BUS1, 4'h0, SPD|AS,    8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 8'h40, 8'hFF, 1'b1, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[11] = v(0, BUS2_BUS1, 4'h0, 9'h0,      8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'hFF, 1'b1, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[12] = v(0, BUS2_BUS1, 4'h0, 9'h0,      8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'hFF, 1'b1, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[13] = v(0, BUS2_BUS1, 4'h0, 9'h0,      8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'hFF, 1'b1, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[14] = v(0, BUS2_ALU,  4'h0, SPL,       8'h80, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'h80, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[15] = v(0, BUS2_BUS1, 4'h0, SPI|SPD,   8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'h80, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[16] = v(0, BUS2_BUS1, 4'h0, SPD,       8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'h7F, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[17] = v(4, BUS2_BUS1, 4'h0, AS,        8'h00, 8'h00, 4'h0, 8'h33, 8'h7F, 8'h40, 8'h7F, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[18] = v(0, BUS2_BUS1, 4'h0, SPI,       8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'h80, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[19] = v(0, BUS2_ALU,  4'h0, SPL,       8'hFF, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'hFF, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[20] = v(0, BUS2_BUS1, 4'h0, SPI,       8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'h00, 1'b1, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[21] = v(0, BUS2_ALU,  4'h0, SPL|SPD,   8'h10, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'h10, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'h0);
    vt[22] = v(0, BUS2_BUS1, 4'h0, CCRL,      8'h00, 8'h00, 4'hA, 8'h40, 8'h01, 8'h40, 8'h10, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'hA);
    vt[23] = v(0, BUS2_ALU,  4'h0, SPL,       8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'h00, 1'b0, 32'h5A3300A5, 8'hFF, 8'h01, 4'hA);
    vt[24] = v(0, BUS2_BUS1, 4'h0, SPD,       8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'hFF, 1'b1, 32'h5A3300A5, 8'hFF, 8'h01, 4'hA);
    vt[25] = v(0, BUS2_BUS1, 4'h0, SPD,       8'h00, 8'h00, 4'h0, 8'h40, 8'h01, 8'h40, 8'hFE, 1'b1, 32'h5A3300A5, 8'hFF, 8'h01, 4'hA);

    reset = 1'b1;
    drive8(v(0, BUS2_BUS1, 4'h0, 9'h0, 8'h00, 8'h00, 4'h0,
             8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 32'h0, 8'h00, 8'h00, 4'h0));
    idle16();
    #12;
    chk("por PC",        64'(bus8.PC),        64'h00);
    chk("por SP",        64'(bus8.SP),        64'hFF);
    chk("por Regs",      64'(bus8.Regs),      64'h0);
    chk("por Stack_Err", 64'(bus8.Stack_Err), 64'h0);
    chk("por SP16",      64'(bus16.SP),       64'hFFFF);
    reset = 1'b0;
    @(posedge clock);
    #1;

    for (int i = 0; i < NV; i++) step8(i);

    // Mid-cycle asynchronous reset with state loaded and the stack flag set
    #3;
    reset = 1'b1;
    #1;
    chk("rst PC",        64'(bus8.PC),        64'h00);
    chk("rst SP",        64'(bus8.SP),        64'hFF);
    chk("rst Regs",      64'(bus8.Regs),      64'h0);
    chk("rst Stack_Err", 64'(bus8.Stack_Err), 64'h0);
    chk("rst IR",        64'(bus8.IR),        64'h00);
    chk("rst MAR",       64'(bus8.MAR),       64'h00);
    chk("rst CCR",       64'(bus8.CCR),       64'h0);
    chk("rst address",   64'(bus8.address),   64'h00);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Wide build: R7 from memory, read back on Bus1, CCR load, out-of-range select
    bus16.Bus2_Sel    = BUS2_MEM;
    bus16.from_memory = 16'hBEEF;
    bus16.Reg_Load    = 8'h80;
    @(posedge clock);
    #1;
    chk("w16 R7",        64'(bus16.Regs[127:112]), 64'hBEEF);
    chk("w16 R0..R6",    64'(bus16.Regs[111:64]),  64'h0);
    chk("w16 R0..R6 lo", 64'(bus16.Regs[63:0]),    64'h0);
    bus16.Reg_Load = 8'h00;
    bus16.Bus1_Sel = 4'd9;
    bus16.CCR_Load = 1'b1;
    bus16.NZVC     = 4'b1010;
    #1;
    chk("w16 to_memory R7", 64'(bus16.to_memory), 64'hBEEF);
    @(posedge clock);
    #1;
    chk("w16 CCR", 64'(bus16.CCR), 64'hA);
    bus16.CCR_Load = 1'b0;
    bus16.Bus1_Sel = 4'd10;
    #1;
    chk("w16 to_memory sel10", 64'(bus16.to_memory), 64'h0);
    bus16.Bus1_Sel = 4'd15;
    #1;
    chk("w16 to_memory sel15", 64'(bus16.to_memory), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/caminho_dados_param.md
# caminho_dados_param

Parametrised next-generation processor datapath: a WIDTH-bit, two-bus datapath with an NREGS-entry general register file, program counter, instruction register, memory address register, 4-bit NZVC condition register, and a new hardware stack pointer with push/pop support and a sticky stack-error flag. It sits between the control-unit FSM, which drives all select and load strobes, the external ALU, which consumes register values and returns ALU_Result/NZVC, and the synchronous memory. All state is held here; the block contains no decode logic.

## Interface
Parameters:
- WIDTH, 8, datapath and address width in bits (≥4)
- NREGS, 4, number of general registers R0..R(NREGS-1) (2..16)
- SP_INIT, all-ones, stack pointer reset value (WIDTH bits)

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- Bus1_Sel  in  SELW=$clog2(NREGS+2)  Bus1 source: 0=PC, 1=SP, 2+n=Rn
- Bus2_Sel  in  2  Bus2 source: 0=Bus1, 1=constant 1, 2=from_memory, 3=ALU_Result
- Reg_Load  in  NREGS  per-register load enable, Rn <= Bus2
- PC_Load, PC_Inc, IR_Load, MAR_Load, CCR_Load  in  1 each  load/increment strobes
- SP_Load, SP_Inc, SP_Dec  in  1 each  stack pointer controls
- Addr_Sel  in  1  address source: 0=MAR, 1=SP
- ALU_Result, from_memory  in  WIDTH  ALU output and memory read data
- NZVC  in  4  ALU flags
- to_memory, address  out  WIDTH  memory write data (=Bus1) and address
- IR, PC, MAR, SP  out  WIDTH  register contents
- CCR  out  4  condition codes
- Regs  out  NREGS*WIDTH  flattened register file, Rn at [n*WIDTH +: WIDTH]
- Stack_Err  out  1  sticky stack overflow/underflow flag

## Operation
- Bus1 and Bus2 are combinational muxes. A Bus1_Sel value ≥ NREGS+2 drives 0, never X.
- to_memory = Bus1; address = Addr_Sel ? SP : MAR. Both are combinational.
- Every register loads Bus2 when its load strobe is high. Any number of Reg_Load bits may be set at once; all selected registers load the same value.
- PC priority: PC_Load, then PC_Inc, then hold. Increment wraps modulo 2^WIDTH.
- SP priority: SP_Load (SP <= Bus2), then SP_Inc XOR SP_Dec (±1, wrapping modulo 2^WIDTH), then hold. SP_Inc and SP_Dec together hold SP.
- Stack_Err is set on SP_Dec when SP=0, or on SP_Inc when SP=all-ones, provided SP_Load is low. The wrap still occurs. Stack_Err is cleared only by reset or SP_Load. When set and clear coincide, clear wins.
- CCR <= NZVC when CCR_Load is high.
- Push sequence (control-unit side): cycle 1 asserts SP_Dec. Cycle 2 asserts Addr_Sel=1 and drives the data on Bus1. Pop is the mirror image: read at SP, then SP_Inc.

## Timing
- Reset is asynchronous, active-high, and takes effect mid-cycle. Reset values: IR, PC, MAR, CCR, and all Rn = 0; SP = SP_INIT; Stack_Err = 0. Outputs reflect these values immediately.
- Every load, increment and decrement is visible on the outputs the cycle after the strobe (1-cycle latency).
- Bus and address paths have zero latency.
- A register can be read on Bus1 and reloaded through Bus2 in the same cycle. The old value is read; the new value is stored at the edge.
- No handshake; strobes are sampled every rising edge.

## Structure
- Package dp_pkg holds:
  - Bus2 select constants BUS2_BUS1/BUS2_ONE/BUS2_MEM/BUS2_ALU
  - Bus1 encodings SEL_PC=0 and SEL_SP=1, with base SEL_R0=2
  - Addr_Sel encodings
  - the SELW computation function
- Sub-module dp_reg: WIDTH-parameterised register with a reset-value parameter and load enable. It is instantiated for IR, MAR, CCR and each Rn via a generate loop. PC and SP keep dedicated logic.

## Test plan
- Reset mid-cycle with all registers loaded → PC=0x00, SP=0xFF, Regs=0, Stack_Err=0 immediately, before the next edge.
- Bus1_Sel=2+3, Bus2_Sel=0, Reg_Load=0b0001 with R3=0x5A → R0=0x5A next cycle. Bus1_Sel=7 (out of range) with Bus2_Sel=0 → Bus2 and to_memory = 0x00.
- PC=0xFF with PC_Inc → PC=0x00. PC_Load and PC_Inc together with Bus2=0x40 → PC=0x40.
- SP=0x00 with SP_Dec → SP=0xFF and Stack_Err=1. Holds for 3 cycles. SP_Load with Bus2=0x80 → SP=0x80, Stack_Err=0.
- SP_Inc and SP_Dec together → SP unchanged, no error. Push sequence: SP_Dec, then Addr_Sel=1 → address = old SP − 1, to_memory = selected register.
- WIDTH=16, NREGS=8 build: load R7 via from_memory=0xBEEF → Regs[127:112]=0xBEEF. CCR_Load with NZVC=0b1010 → CCR=0xA.
